// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Brief    : MM:SS BCD stopwatch (00:00-59:59) driven by synchronised edges
//            of an external seconds tick and two push-buttons.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter (
  input  logic       clock,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [3:0] c_digit_max_nine = 4'd9;
  localparam logic [3:0] c_digit_max_five = 4'd5;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_run   = 2'd1,
    st_pause = 2'd2
  } state_t;

  // Bit order for the edge-detect vectors: [2]=clear, [1]=start_stop, [0]=tick_in
  logic [2:0] w_async_in;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_hist;
  logic [2:0] w_pulse;
  logic       w_tick_p;
  logic       w_start_p;
  logic       w_clear_p;

  state_t     r_state;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic       r_running;
  logic       r_rollover;

  logic [3:0] w_nxt_sec_ones;
  logic [3:0] w_nxt_sec_tens;
  logic [3:0] w_nxt_min_ones;
  logic [3:0] w_nxt_min_tens;
  logic       w_wrap;

  assign w_async_in = {clear, start_stop, tick_in};

  // Flops preset to 1 so a level already high at reset release is not an edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_hist  <= '1;
    end else begin
      r_sync1 <= w_async_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_pulse   = r_sync2 & ~r_hist;
  assign w_tick_p  = w_pulse[0];
  assign w_start_p = w_pulse[1];
  assign w_clear_p = w_pulse[2];

  // BCD cascade; >= comparisons keep every digit inside its range.
  always_comb begin
    w_nxt_sec_ones = r_sec_ones + 4'd1;
    w_nxt_sec_tens = r_sec_tens;
    w_nxt_min_ones = r_min_ones;
    w_nxt_min_tens = r_min_tens;
    w_wrap         = 1'b0;
    if (r_sec_ones >= c_digit_max_nine) begin
      w_nxt_sec_ones = 4'd0;
      w_nxt_sec_tens = r_sec_tens + 4'd1;
      if (r_sec_tens >= c_digit_max_five) begin
        w_nxt_sec_tens = 4'd0;
        w_nxt_min_ones = r_min_ones + 4'd1;
        if (r_min_ones >= c_digit_max_nine) begin
          w_nxt_min_ones = 4'd0;
          w_nxt_min_tens = r_min_tens + 4'd1;
          if (r_min_tens >= c_digit_max_five) begin
            w_nxt_min_tens = 4'd0;
            w_wrap         = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= st_idle;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_running  <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      if (w_clear_p) begin
        r_state    <= st_idle;
        r_sec_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_min_tens <= 4'd0;
        r_running  <= 1'b0;
      end else begin
        // Tick is qualified by the pre-edge state, so tick+start in PAUSE does not count.
        if (w_tick_p && (r_state == st_run)) begin
          r_sec_ones <= w_nxt_sec_ones;
          r_sec_tens <= w_nxt_sec_tens;
          r_min_ones <= w_nxt_min_ones;
          r_min_tens <= w_nxt_min_tens;
          r_rollover <= w_wrap;
        end
        if (w_start_p) begin
          case (r_state)
            st_idle: begin
              r_state   <= st_run;
              r_running <= 1'b1;
            end
            st_run: begin
              r_state   <= st_pause;
              r_running <= 1'b0;
            end
            st_pause: begin
              r_state   <= st_run;
              r_running <= 1'b1;
            end
            default: begin
              r_state   <= st_idle;
              r_running <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign min_tens = r_min_tens;
  assign running  = r_running;
  assign rollover = r_rollover;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_counter
// Brief    : Scoreboard bench for stopwatch_counter against a seconds-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

  logic       clock;
  logic       rst;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       rollover;

  stopwatch_counter dut (
    .clock     (clock),
    .rst       (rst),
    .tick_in   (tick_in),
    .start_stop(start_stop),
    .clear     (clear),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .running   (running),
    .rollover  (rollover)
  );

  localparam int c_idle  = 0;
  localparam int c_run   = 1;
  localparam int c_pause = 2;

  typedef struct packed {
    logic [15:0] digits;
    logic        run;
    logic        roll;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: elapsed time as plain seconds, state as a small integer.
  int         m_secs  = 0;
  int         m_st    = c_idle;
  logic [2:0] m_prev  = 3'b111;
  logic [2:0] m_pend [4];
  int         m_step  = 0;
  logic       m_rst_q = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] digits_of(input int secs);
    int s;
    int m;
    s = secs % 60;
    m = secs / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after it.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("digits",   {min_tens, min_ones, sec_tens, sec_ones}, e.digits);
      check("running",  16'(running),  16'(e.run));
      check("rollover", 16'(rollover), 16'(e.roll));
    end
  end

  // One stimulus step per clock: drive levels at negedge, advance model for the next edge.
  task automatic step(input logic t, input logic s, input logic c, input logic r);
    logic [2:0] lv;
    logic [2:0] ev;
    logic       roll;
    exp_t       e;
    lv         = {c, s, t};
    tick_in    = t;
    start_stop = s;
    clear      = c;
    rst        = r;
    roll       = 1'b0;
    if (r) begin
      m_secs = 0;
      m_st   = c_idle;
      m_prev = 3'b111;
      for (int i = 0; i < 4; i++) m_pend[i] = 3'b000;
    end else begin
      m_pend[(m_step + 2) % 4] = lv & ~m_prev;
      m_prev = lv;
      ev = m_pend[m_step % 4];
      m_pend[m_step % 4] = 3'b000;
      if (ev[2]) begin
        m_st   = c_idle;
        m_secs = 0;
      end else begin
        if (ev[0] && (m_st == c_run)) begin
          roll   = (m_secs == 3599);
          m_secs = (m_secs + 1) % 3600;
        end
        if (ev[1]) m_st = (m_st == c_run) ? c_pause : c_run;
      end
    end
    e.digits = digits_of(m_secs);
    e.run    = (m_st == c_run);
    e.roll   = roll;
    exp_q.push_back(e);
    if (r && !m_rst_q) begin
      #1;
      check("async_rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
      check("async_rst_running", 16'(running), 16'h0);
    end
    m_rst_q = r;
    m_step++;
    @(negedge clock);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_start();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_clear();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    tick_in    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    for (int i = 0; i < 4; i++) m_pend[i] = 3'b000;
    @(negedge clock);

    // Reset, then start and three ticks
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    press_start();
    tick_n(3);
    settle();

    // 00:58 -> 00:59 -> 01:00
    press_clear();
    press_start();
    tick_n(58);
    settle();
    tick_n(2);
    settle();

    // Continue to 59:59, then wrap with rollover
    tick_n(3539);
    settle();
    tick_n(1);
    settle();
    tick_n(2);

    // Pause ignores ticks, resume continues
    press_clear();
    press_start();
    tick_n(5);
    press_start();
    tick_n(4);
    press_start();
    tick_n(1);
    settle();

    // Clear and start aligned in RUN at 00:07
    press_clear();
    press_start();
    tick_n(7);
    settle();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Tick+start in RUN, tick+start in PAUSE, clear+tick
    press_start();
    tick_n(2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(1);
    settle();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // start_stop held high across reset release
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    settle();

    // Reset mid-count at 02:13
    press_start();
    tick_n(133);
    settle();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    settle();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom % 2), ($urandom % 6) == 0, ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    settle();

    repeat (2) @(posedge clock);
    #2;
    check("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have no parameters; the count range is fixed at 00:00 to 59:59 (MM:SS).
REQ-002 The block SHALL have port `clock`, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port `tick_in`, input, 1 bit: divided clock level from the upstream clock divider, asynchronous to `clock`; each rising edge is one second.
REQ-005 The block SHALL have port `start_stop`, input, 1 bit: push-button level, asynchronous; each rising edge toggles run/pause.
REQ-006 The block SHALL have port `clear`, input, 1 bit: push-button level, asynchronous; each rising edge returns to zero/idle.
REQ-007 The block SHALL have port `sec_ones`, output, 4 bits: BCD seconds units, 0-9.
REQ-008 The block SHALL have port `sec_tens`, output, 4 bits: BCD seconds tens, 0-5.
REQ-009 The block SHALL have port `min_ones`, output, 4 bits: BCD minutes units, 0-9.
REQ-010 The block SHALL have port `min_tens`, output, 4 bits: BCD minutes tens, 0-5.
REQ-011 The block SHALL have port `running`, output, 1 bit: high exactly while the state is RUN.
REQ-012 The block SHALL have port `rollover`, output, 1 bit: one-cycle pulse on wrap from 59:59 to 00:00.

Function
REQ-013 Each of `tick_in`, `start_stop` and `clear` SHALL pass through a 2-flop synchronizer.
REQ-014 A history flop SHALL follow each synchronizer; the internal pulse is sync2 AND NOT history.
REQ-015 Each internal pulse SHALL be exactly one `clock` cycle wide per input rising edge.
REQ-016 An input rising edge first sampled high at clock edge N SHALL take effect (count/state update) at clock edge N+2.
REQ-017 An input rising edge first sampled high at clock edge N SHALL be visible on the outputs after edge N+2.
REQ-018 The FSM states SHALL be IDLE, RUN and PAUSE.
REQ-019 The FSM transitions SHALL be: IDLE + start pulse -> RUN; RUN + start pulse -> PAUSE; PAUSE + start pulse -> RUN.
REQ-020 A clear pulse SHALL force IDLE and all digits to 0 from any state.
REQ-021 When clear and start pulses coincide, clear SHALL win: IDLE, zero, no run.
REQ-022 When clear and tick pulses coincide, clear SHALL win: the tick is discarded.
REQ-023 A tick pulse SHALL increment the count only when the current (pre-edge) state is RUN.
REQ-024 Ticks in IDLE or PAUSE SHALL be ignored and SHALL NOT be queued.
REQ-025 A tick and a start pulse in the same cycle while in RUN SHALL increment the count and enter PAUSE.
REQ-026 A tick and a start pulse in the same cycle while in PAUSE SHALL NOT increment the count and SHALL enter RUN.
REQ-027 Increment SHALL be a BCD cascade: `sec_ones` 9->0 carries to `sec_tens`; `sec_tens` 5->0 carries to `min_ones`; `min_ones` 9->0 carries to `min_tens`; `min_tens` 5->0 wraps.
REQ-028 On the tick at 59:59 the count SHALL become 00:00, `rollover` SHALL be 1 for that one cycle, and the state SHALL remain RUN.
REQ-029 Digits SHALL never hold a non-BCD value or exceed the ranges in REQ-007 to REQ-010.
REQ-030 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 While `rst` = 1, the block SHALL asynchronously set state to IDLE, all digits to 0, `running` to 0 and `rollover` to 0.
REQ-032 While `rst` = 1, all synchronizer and history flops SHALL be forced to 1, so inputs held high through reset release produce no pulse.
REQ-033 Reset asserted mid-count SHALL discard the count immediately, without waiting for a clock edge.
REQ-034 After `rst` falls, the block SHALL stay in IDLE until a fresh start edge arrives.

Verification
REQ-035 The bench SHALL cover: reset, then start edge, then 3 `tick_in` edges -> `running` = 1 and digits read 00:03; each update on the 3rd `clock` edge after the input edge.
REQ-036 The bench SHALL cover: RUN at 00:58, then 2 ticks -> 00:59 followed by 01:00, with `sec_tens` carrying into `min_ones`.
REQ-037 The bench SHALL cover: preload by ticking to 59:59, then 1 tick -> 00:00 with `rollover` high exactly 1 cycle and `running` still 1.
REQ-038 The bench SHALL cover: RUN at 00:05, start edge, then 4 ticks -> PAUSE and count stays 00:05; a further start edge plus 1 tick -> 00:06.
REQ-039 The bench SHALL cover: clear and start edges aligned in RUN at 00:07 -> IDLE, 00:00, `running` = 0.
REQ-040 The bench SHALL cover: `start_stop` held high across reset release -> stays IDLE; `rst` pulsed mid-count at 02:13 -> outputs zero before the next `clock` edge.
